// File: rtl/uart_rx_deser_param_if.sv
// Word-side handshake of the UART RX deserialiser: received word, error flags and valid/ready.
// master: the deserialiser producing words; slave: the FIFO/host consuming them.
interface uart_rx_deser_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] PARALLEL_DATA;
  logic              DATA_VALID;
  logic              DATA_READY;
  logic              FRAME_ERR;
  logic              PARITY_ERR;

  modport master (
    output PARALLEL_DATA, DATA_VALID, FRAME_ERR, PARITY_ERR,
    input  DATA_READY
  );

  modport slave (
    input  PARALLEL_DATA, DATA_VALID, FRAME_ERR, PARITY_ERR,
    output DATA_READY
  );
endinterface

// File: rtl/uart_rx_deser_param.sv
// UART receive deserialiser: start-bit qualification at mid-bit, DATA_W data bits sampled
// once per OVERSAMPLE ticks, stop-bit check, word presented on a valid/ready handshake with
// overrun detection. Optional parity stage is compiled in with UART_DESER_PARITY_EN.
module uart_rx_deser_param #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic                           RX_tick,
  input  logic                           SER_DATA,
`ifdef UART_DESER_PARITY_EN
  input  logic                           PARITY_ODD,
`endif
  uart_rx_deser_param_if.master          rx,
  output logic                           OVERRUN,
  output logic                           BUSY
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] MID_C   = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] LAST_C  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_END = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic              take_bit, done;
  logic [DATA_W-1:0] shreg, data_q;
  logic              valid_q, ferr_q, ovr_q;
`ifdef UART_DESER_PARITY_EN
  logic              take_par, par_bit, perr_q;
`endif

  // State, tick counter and bit index registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic; everything advances only on RX_tick, and EN=0 forces IDLE
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    take_bit = 1'b0;
    done     = 1'b0;
`ifdef UART_DESER_PARITY_EN
    take_par = 1'b0;
`endif
    if (!EN) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else if (RX_tick) begin
      case (state)
        IDLE: if (!SER_DATA) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
        end
        // Qualify the start bit at its middle; counter restart aligns later samples to mid-bit
        START: if (cnt == MID_C) begin
          cnt_n   = '0;
          state_n = SER_DATA ? IDLE : DATA;
        end else cnt_n = cnt + 1'b1;
        DATA: if (cnt == LAST_C) begin
          cnt_n    = '0;
          take_bit = 1'b1;
          if (idx == IDX_END) begin
            idx_n = '0;
`ifdef UART_DESER_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else idx_n = idx + 1'b1;
        end else cnt_n = cnt + 1'b1;
`ifdef UART_DESER_PARITY_EN
        PARITY: if (cnt == LAST_C) begin
          cnt_n    = '0;
          take_par = 1'b1;
          state_n  = STOP;
        end else cnt_n = cnt + 1'b1;
`endif
        STOP: if (cnt == LAST_C) begin
          cnt_n   = '0;
          done    = 1'b1;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  // Shift register, output word/flags, handshake and sticky overrun
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_DESER_PARITY_EN
      par_bit <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      if (!EN) begin
        shreg <= '0;
        ovr_q <= 1'b0;
      end
      if (take_bit) begin
        if (MSB_FIRST) shreg <= {shreg[DATA_W-2:0], SER_DATA};
        else           shreg <= {SER_DATA, shreg[DATA_W-1:1]};
      end
`ifdef UART_DESER_PARITY_EN
      if (take_par) par_bit <= SER_DATA;
`endif
      if (done) begin
        // A held, unaccepted word wins; the new one is dropped and flagged
        if (!valid_q || rx.DATA_READY) begin
          data_q  <= shreg;
          ferr_q  <= ~SER_DATA;
          valid_q <= 1'b1;
`ifdef UART_DESER_PARITY_EN
          perr_q  <= ((^shreg) ^ par_bit) != PARITY_ODD;
`endif
        end else ovr_q <= 1'b1;
      end else if (valid_q && rx.DATA_READY) valid_q <= 1'b0;
    end
  end

  assign rx.PARALLEL_DATA = data_q;
  assign rx.DATA_VALID    = valid_q;
  assign rx.FRAME_ERR     = ferr_q;
`ifdef UART_DESER_PARITY_EN
  assign rx.PARITY_ERR    = perr_q;
`else
  assign rx.PARITY_ERR    = 1'b0;
`endif
  assign OVERRUN = ovr_q;
  assign BUSY    = (state != IDLE);
endmodule
